mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register plus writeback control for the pipelined LEGv8 core.

---
 rtl/mem_wb_stage.sv | 111 +++++++++++
 tb/tb_mem_wb_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Purpose  : MEM/WB pipeline register with register-file writeback control,
//             WB-to-EX forwarding hit detection and a saturating
//             retired-instruction counter for the pipelined LEGv8 core.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wb_stage #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_to_reg_data,
  input  logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_reg_write,
  input  logic [ADDR_W-1:0] ex_rn_addr,
  input  logic [ADDR_W-1:0] ex_rm_addr,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_rd_addr,
  output logic              wb_reg_write,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [CNT_W-1:0]  retire_count
);

  // XZR index at register-address width; writes to it are discarded.
  localparam logic [ADDR_W-1:0] c_zero_reg = ADDR_W'(ZERO_REG);
  // Saturation ceiling of the retire counter.
  localparam logic [CNT_W-1:0]  c_cnt_max  = {CNT_W{1'b1}};

  // Stage registers and their next-state values.
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [ADDR_W-1:0] rd_q,    rd_d;
  logic              rw_q,    rw_d;
  logic [CNT_W-1:0]  retire_count_q, retire_count_d;

  // An instruction is accepted into WB only on a free-running, unflushed edge.
  logic w_accept;
  logic w_write_en;

  assign w_accept = ~flush & ~stall;

  // Next stage contents: flush beats stall, stall beats a normal load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      rd_d    = '0;
      rw_d    = 1'b0;
    end else if (!stall) begin
      valid_d = mem_valid;
      data_d  = mem_to_reg_data;
      rd_d    = mem_rd_addr;
      // A bubble must never carry a write enable forward.
      rw_d    = mem_reg_write & mem_valid;
    end
  end

  // Retire count advances once per accepted real instruction and sticks at all-ones.
  always_comb begin
    retire_count_d = retire_count_q;
    if (w_accept && mem_valid && (retire_count_q != c_cnt_max)) begin
      retire_count_d = retire_count_q + 1'b1;
    end
  end

  // Stage register with asynchronous clear so outputs drop the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= 1'b0;
      data_q         <= '0;
      rd_q           <= '0;
      rw_q           <= 1'b0;
      retire_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      data_q         <= data_d;
      rd_q           <= rd_d;
      rw_q           <= rw_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Register-file write is suppressed for XZR; a stalled write simply repeats.
  assign w_write_en = valid_q & rw_q & (rd_q != c_zero_reg);

  // Forwarding looks only at registered WB state, never at the MEM inputs.
  assign fwd_a_hit    = w_write_en & (ex_rn_addr == rd_q);
  assign fwd_b_hit    = w_write_en & (ex_rm_addr == rd_q);

  assign wb_valid     = valid_q;
  assign wb_data      = data_q;
  assign wb_rd_addr   = rd_q;
  assign wb_reg_write = w_write_en;
  assign retire_count = retire_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Purpose  : Directed self-checking bench for mem_wb_stage (default build and
//             a 4-bit retire-counter build sharing the same stimulus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [63:0] mem_to_reg_data = '0;
  logic [4:0]  mem_rd_addr = '0;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  ex_rn_addr = '0;
  logic [4:0]  ex_rm_addr = '0;

  logic        wb_valid, wb_reg_write, fwd_a_hit, fwd_b_hit;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd_addr;
  logic [31:0] retire_count;

  logic        s_valid, s_reg_write, s_fwd_a, s_fwd_b;
  logic [63:0] s_data;
  logic [4:0]  s_rd;
  logic [3:0]  s_retire;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_to_reg_data(mem_to_reg_data),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .ex_rn_addr(ex_rn_addr), .ex_rm_addr(ex_rm_addr),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
    .wb_reg_write(wb_reg_write), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .retire_count(retire_count)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_to_reg_data(mem_to_reg_data),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .ex_rn_addr(ex_rn_addr), .ex_rm_addr(ex_rm_addr),
    .wb_valid(s_valid), .wb_data(s_data), .wb_rd_addr(s_rd),
    .wb_reg_write(s_reg_write), .fwd_a_hit(s_fwd_a), .fwd_b_hit(s_fwd_b),
    .retire_count(s_retire)
  );

  // ---------------- behavioural model ----------------
  // The WB stage is "the last instruction accepted"; a flush replaces it by an
  // empty slot. Retirements are an unbounded integer; each build saturates it.
  typedef struct {
    bit          present;
    bit [63:0]   data;
    bit [4:0]    rd;
    bit          writes;
  } instr_t;

  instr_t m_slot;
  longint m_retired;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_slot    = '{0, 0, 0, 0};
      m_retired = 0;
    end else if (flush) begin
      m_slot = '{0, 0, 0, 0};
    end else if (!stall) begin
      m_slot = '{mem_valid, mem_to_reg_data, mem_rd_addr, mem_reg_write && mem_valid};
      if (mem_valid) m_retired++;
    end
  end

  function automatic bit exp_we();
    return m_slot.present && m_slot.writes && (m_slot.rd != 5'd31);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  // Every falling edge: full output set of both builds against the model.
  always @(negedge clk) begin
    cycle++;
    chk("cmp_valid",  {63'd0, wb_valid},     {63'd0, m_slot.present});
    chk("cmp_data",   wb_data,               m_slot.data);
    chk("cmp_rd",     {59'd0, wb_rd_addr},   {59'd0, m_slot.rd});
    chk("cmp_we",     {63'd0, wb_reg_write}, {63'd0, exp_we()});
    chk("cmp_fwd_a",  {63'd0, fwd_a_hit},    {63'd0, exp_we() && (ex_rn_addr == m_slot.rd)});
    chk("cmp_fwd_b",  {63'd0, fwd_b_hit},    {63'd0, exp_we() && (ex_rm_addr == m_slot.rd)});
    chk("cmp_cnt32",  {32'd0, retire_count}, 64'(m_retired));
    chk("cmp_cnt4",   {60'd0, s_retire},     (m_retired > 15) ? 64'd15 : 64'(m_retired));
    chk("cmp_we4",    {63'd0, s_reg_write},  {63'd0, exp_we()});
  end

  // ---------------- stimulus ----------------
  // Apply MEM inputs now (2 time units after an edge) and move past the next edge.
  task automatic step(input logic v, input logic [63:0] d, input logic [4:0] rd,
                      input logic rw, input logic st, input logic fl);
    mem_valid       = v;
    mem_to_reg_data = d;
    mem_rd_addr     = rd;
    mem_reg_write   = rw;
    stall           = st;
    flush           = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic set_ex(input logic [4:0] rn, input logic [4:0] rm);
    ex_rn_addr = rn;
    ex_rm_addr = rm;
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_cnt",   {32'd0, retire_count}, 64'd0);
    rst_n = 1'b1;

    // 1: basic load
    step(1, 64'hDEAD_BEEF, 5'd5, 1, 0, 0);
    chk("t1_we",   {63'd0, wb_reg_write}, 64'd1);
    chk("t1_rd",   {59'd0, wb_rd_addr}, 64'd5);
    chk("t1_data", wb_data, 64'hDEAD_BEEF);
    chk("t1_cnt",  {32'd0, retire_count}, 64'd1);

    // 2: XZR destination
    step(1, 64'h1234, 5'd31, 1, 0, 0);
    set_ex(5'd31, 5'd0);
    chk("t2_we",   {63'd0, wb_reg_write}, 64'd0);
    chk("t2_fwda", {63'd0, fwd_a_hit}, 64'd0);
    chk("t2_cnt",  {32'd0, retire_count}, 64'd2);

    // 3: hold rd=7 across a 3-cycle stall with changing inputs
    step(1, 64'h77, 5'd7, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 64'(32'hA000 + i), 5'(10 + i), 1, 1, 0);
      set_ex(5'd0, 5'd7);
      chk("t3_rd",   {59'd0, wb_rd_addr}, 64'd7);
      chk("t3_data", wb_data, 64'h77);
      chk("t3_cnt",  {32'd0, retire_count}, 64'd3);
      chk("t3_fwdb", {63'd0, fwd_b_hit}, 64'd1);
      chk("t3_fwda", {63'd0, fwd_a_hit}, 64'd0);
    end
    set_ex(5'd7, 5'd7);
    chk("t3_both", {62'd0, fwd_a_hit, fwd_b_hit}, 64'd3);

    // 4: stall and flush together
    step(1, 64'h99, 5'd9, 1, 1, 1);
    chk("t4_valid", {63'd0, wb_valid}, 64'd0);
    chk("t4_we",    {63'd0, wb_reg_write}, 64'd0);
    chk("t4_cnt",   {32'd0, retire_count}, 64'd3);
    // Bubble with RegWrite set must not write or count
    step(0, 64'h55, 5'd4, 1, 0, 0);
    chk("t4_bubble_we", {63'd0, wb_reg_write}, 64'd0);
    chk("t4_bubble_cnt", {32'd0, retire_count}, 64'd3);

    // 5: drive the 4-bit counter to saturation (3 + 14 = 17 retirements)
    for (int i = 0; i < 14; i++) step(1, 64'(i * 3), 5'(i), i[0], 0, 0);
    chk("t5_sat",  {60'd0, s_retire}, 64'hF);
    step(1, 64'hF00D, 5'd3, 1, 0, 0);
    chk("t5_hold", {60'd0, s_retire}, 64'hF);
    chk("t5_cnt32", {32'd0, retire_count}, 64'd18);

    // 6: asynchronous reset between edges with valid data held
    step(1, 64'hABC, 5'd12, 1, 0, 0);
    set_ex(5'd12, 5'd12);
    chk("t6_pre_we", {63'd0, wb_reg_write}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {63'd0, wb_valid}, 64'd0);
    chk("t6_data",  wb_data, 64'd0);
    chk("t6_we",    {63'd0, wb_reg_write}, 64'd0);
    chk("t6_fwd",   {62'd0, fwd_a_hit, fwd_b_hit}, 64'd0);
    chk("t6_cnt",   {32'd0, retire_count}, 64'd0);
    // Reset held through an edge with stall/flush asserted
    step(1, 64'h1, 5'd1, 1, 1, 1);
    chk("t6_hold_rst", {63'd0, wb_valid}, 64'd0);
    rst_n = 1'b1;
    step(1, 64'h2, 5'd2, 1, 1, 0);
    chk("t6_after_stall", {59'd0, wb_rd_addr}, 64'd0);
    step(1, 64'h3, 5'd6, 1, 0, 0);
    chk("t6_reload_cnt", {32'd0, retire_count}, 64'd1);
    chk("t6_reload_rd",  {59'd0, wb_rd_addr}, 64'd6);

    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
